// File: rtl/usb_tx.sv
// usb_tx: USB full-speed packet transmitter.
// Takes a packet request, then serialises SYNC, PID, an optional payload
// pulled from the shared data buffer, and CRC16. The bit stream is bit-stuffed,
// NRZI encoded and closed with an EOP.
// Ports:
//   clk, rst            - single clock; synchronous active-high reset
//   tx_packet           - request code: 1 DATA0, 2 ACK, 3 NAK, 4 STALL, 5-15 invalid
//   buffer_occupancy    - payload bytes available, latched on a DATA0 accept
//   tx_packet_data      - buffer read data, valid the cycle after a pop
//   get_tx_packet_data  - one-cycle buffer pop strobe
//   dplus_out/dminus_out- bus line drive (J = 1/0, K = 0/1, SE0 = 0/0)
//   tx_transfer_active  - high from accept through the last EOP bit
//   tx_error            - one-cycle pulse on an invalid request code
module usb_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned MAX_BYTES    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       tx_transfer_active,
  output logic       tx_error
);

  localparam int unsigned BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP_SE0, S_EOP_J
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [BCW-1:0]   r_bitcnt, w_bitcnt_nxt;
  logic [2:0]       r_bitidx, w_bitidx_nxt;
  logic [7:0]       r_byte, w_byte_nxt;
  logic [2:0]       r_ones, w_ones_nxt;
  logic             r_dp, w_dp_nxt;
  logic             r_dm, w_dm_nxt;
  logic             r_active, w_active_nxt;
  logic             r_err, w_err_nxt;
  logic [3:0]       r_pid, w_pid_nxt;
  logic             r_is_data, w_is_data_nxt;
  logic [6:0]       r_count, w_count_nxt;
  logic             r_have, w_have_nxt;
  logic [15:0]      r_crc, w_crc_nxt;

  logic             w_tick;
  logic             w_last_bit;
  logic             w_get;
  logic             w_send;
  logic             w_bit;
  logic             w_load;
  logic [7:0]       w_nbyte;

  // Reflected CRC16 (poly 0x8005 -> 0xA001), data consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] v;
    v = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[0] ^ d[i]) v = (v >> 1) ^ 16'hA001;
      else             v = v >> 1;
    end
    return v;
  endfunction

  assign w_tick = (r_bitcnt == BCW'(CLKS_PER_BIT - 1));
  // The current bit is the final one of its byte unless a stuff bit must follow it.
  assign w_last_bit = (r_bitidx == 3'd7) && (r_ones != 3'd6);
  // Pop one cycle ahead of the bit boundary so the byte is present at the tick.
  assign w_get = ((r_state == S_PID) || (r_state == S_DATA)) && w_last_bit &&
                 (r_count != 7'd0) && (r_bitcnt == BCW'(CLKS_PER_BIT - 2));

  always_comb begin
    w_state_nxt   = r_state;
    w_bitcnt_nxt  = r_bitcnt;
    w_bitidx_nxt  = r_bitidx;
    w_byte_nxt    = r_byte;
    w_ones_nxt    = r_ones;
    w_dp_nxt      = r_dp;
    w_dm_nxt      = r_dm;
    w_active_nxt  = r_active;
    w_err_nxt     = 1'b0;
    w_pid_nxt     = r_pid;
    w_is_data_nxt = r_is_data;
    w_count_nxt   = r_count;
    w_have_nxt    = r_have;
    w_crc_nxt     = r_crc;
    w_send        = 1'b0;
    w_bit         = 1'b0;
    w_load        = 1'b0;
    w_nbyte       = 8'h00;

    if (r_state != S_IDLE)
      w_bitcnt_nxt = w_tick ? '0 : r_bitcnt + BCW'(1);

    if (w_get) begin
      w_count_nxt = r_count - 7'd1;
      w_have_nxt  = 1'b1;
    end

    unique case (r_state)
      S_IDLE: begin
        if ((tx_packet >= 4'd1) && (tx_packet <= 4'd4)) begin
          w_state_nxt   = S_SYNC;
          w_byte_nxt    = 8'h80;
          w_bitidx_nxt  = '0;
          w_bitcnt_nxt  = '0;
          w_crc_nxt     = '1;
          w_have_nxt    = 1'b0;
          w_active_nxt  = 1'b1;
          w_is_data_nxt = (tx_packet == 4'd1);
          w_count_nxt   = '0;
          if (tx_packet == 4'd1)
            w_count_nxt = (buffer_occupancy > 7'(MAX_BYTES)) ? 7'(MAX_BYTES) : buffer_occupancy;
          unique case (tx_packet)
            4'd1:    w_pid_nxt = 4'h3;
            4'd2:    w_pid_nxt = 4'h2;
            4'd3:    w_pid_nxt = 4'hA;
            default: w_pid_nxt = 4'hE;
          endcase
          // First SYNC bit (a 0) goes on the line at the accept edge.
          w_send = 1'b1;
          w_bit  = 1'b0;
        end else if (tx_packet != 4'd0) begin
          w_err_nxt = 1'b1;
        end
      end
      S_EOP_SE0: begin
        if (w_tick) begin
          if (r_bitidx == 3'd0) begin
            w_bitidx_nxt = 3'd1;
          end else begin
            w_state_nxt = S_EOP_J;
            w_dp_nxt    = 1'b1;
            w_dm_nxt    = 1'b0;
          end
        end
      end
      S_EOP_J: begin
        if (w_tick) begin
          w_state_nxt  = S_IDLE;
          w_active_nxt = 1'b0;
        end
      end
      default: begin
        if (w_tick) begin
          if (r_ones == 3'd6) begin
            // Stuff bit: the byte shift register holds for this period.
            w_send = 1'b1;
            w_bit  = 1'b0;
          end else if (r_bitidx != 3'd7) begin
            w_bitidx_nxt = r_bitidx + 3'd1;
            w_byte_nxt   = r_byte >> 1;
            w_send       = 1'b1;
            w_bit        = r_byte[1];
          end else begin
            w_bitidx_nxt = '0;
            w_load       = 1'b1;
            unique case (r_state)
              S_SYNC: begin
                w_state_nxt = S_PID;
                w_nbyte     = {~r_pid, r_pid};
              end
              S_PID, S_DATA: begin
                if (r_have) begin
                  w_state_nxt = S_DATA;
                  w_nbyte     = tx_packet_data;
                  w_crc_nxt   = crc16_byte(r_crc, tx_packet_data);
                  w_have_nxt  = 1'b0;
                end else if (r_is_data) begin
                  w_state_nxt = S_CRC_LO;
                  w_nbyte     = ~r_crc[7:0];
                end else begin
                  w_state_nxt = S_EOP_SE0;
                  w_load      = 1'b0;
                end
              end
              S_CRC_LO: begin
                w_state_nxt = S_CRC_HI;
                w_nbyte     = ~r_crc[15:8];
              end
              default: begin
                w_state_nxt = S_EOP_SE0;
                w_load      = 1'b0;
              end
            endcase
            if (w_load) begin
              w_byte_nxt = w_nbyte;
              w_send     = 1'b1;
              w_bit      = w_nbyte[0];
            end else begin
              w_dp_nxt = 1'b0;
              w_dm_nxt = 1'b0;
            end
          end
        end
      end
    endcase

    // NRZI: a 0 toggles J<->K, a 1 holds; every sent bit updates the run of 1s.
    if (w_send) begin
      w_ones_nxt = w_bit ? r_ones + 3'd1 : '0;
      if (!w_bit) begin
        w_dp_nxt = r_dm;
        w_dm_nxt = r_dp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bitcnt  <= '0;
      r_bitidx  <= '0;
      r_byte    <= '0;
      r_ones    <= '0;
      r_dp      <= 1'b1;
      r_dm      <= 1'b0;
      r_active  <= 1'b0;
      r_err     <= 1'b0;
      r_pid     <= '0;
      r_is_data <= 1'b0;
      r_count   <= '0;
      r_have    <= 1'b0;
      r_crc     <= '1;
    end else begin
      r_state   <= w_state_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_bitidx  <= w_bitidx_nxt;
      r_byte    <= w_byte_nxt;
      r_ones    <= w_ones_nxt;
      r_dp      <= w_dp_nxt;
      r_dm      <= w_dm_nxt;
      r_active  <= w_active_nxt;
      r_err     <= w_err_nxt;
      r_pid     <= w_pid_nxt;
      r_is_data <= w_is_data_nxt;
      r_count   <= w_count_nxt;
      r_have    <= w_have_nxt;
      r_crc     <= w_crc_nxt;
    end
  end

  assign get_tx_packet_data = w_get;
  assign dplus_out          = r_dp;
  assign dminus_out         = r_dm;
  assign tx_transfer_active = r_active;
  assign tx_error           = r_err;

endmodule

// File: tb/tb_usb_tx.sv
// tb_usb_tx: scoreboard bench for usb_tx. Stimulus pushes the expected line
// symbols, byte stream and pop count per packet; a negedge monitor captures each
// packet while tx_transfer_active is high and compares on its falling edge.
module tb_usb_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] tx_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;
  logic       get_tx_packet_data;
  logic       dplus_out;
  logic       dminus_out;
  logic       tx_transfer_active;
  logic       tx_error;

  always #5 clk = ~clk;

  usb_tx #(.CLKS_PER_BIT(CPB), .MAX_BYTES(64)) dut (
    .clk                (clk),
    .rst                (rst),
    .tx_packet          (tx_packet),
    .buffer_occupancy   (buffer_occupancy),
    .tx_packet_data     (tx_packet_data),
    .get_tx_packet_data (get_tx_packet_data),
    .dplus_out          (dplus_out),
    .dminus_out         (dminus_out),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_sym_q[$];
  int         exp_len_q[$];
  int         exp_pops_q[$];
  int         exp_nb_q[$];
  logic [7:0] exp_byte_q[$];
  logic [7:0] buf_q[$];
  logic [7:0] pay_q[$];
  logic [1:0] trace[$];

  bit abort_pkt = 1'b0;
  bit in_pkt    = 1'b0;
  bit pend      = 1'b0;
  int pkt_pops  = 0;
  int idle_pops = 0;
  int err_seen  = 0;
  int exp_err   = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: bytes -> LSB-first bits -> stuffing -> NRZI levels, CRC computed
  // in the non-reflected MSB-first form and bit-reversed at the end.
  task automatic model_push(input logic [3:0] code);
    logic [7:0] bytes[$];
    bit         bits[$];
    logic [1:0] syms[$];
    logic [3:0] pid;
    logic [15:0] c, r;
    logic [7:0] d;
    logic [1:0] lvl;
    int ones;
    case (code)
      4'd1:    pid = 4'h3;
      4'd2:    pid = 4'h2;
      4'd3:    pid = 4'hA;
      default: pid = 4'hE;
    endcase
    bytes.push_back(8'h80);
    bytes.push_back({~pid, pid});
    if (code == 4'd1) begin
      c = 16'hFFFF;
      foreach (pay_q[i]) begin
        d = pay_q[i];
        bytes.push_back(d);
        for (int k = 0; k < 8; k++) begin
          bit fb;
          fb = c[15] ^ d[k];
          c = {c[14:0], 1'b0};
          if (fb) c = c ^ 16'h8005;
        end
      end
      for (int k = 0; k < 16; k++) r[k] = c[15-k];
      bytes.push_back(~r[7:0]);
      bytes.push_back(~r[15:8]);
    end
    foreach (bytes[i]) begin
      d = bytes[i];
      for (int k = 0; k < 8; k++) bits.push_back(d[k]);
    end
    ones = 0;
    lvl  = 2'b10;
    foreach (bits[i]) begin
      if (!bits[i]) lvl = ~lvl;
      syms.push_back(lvl);
      ones = bits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        lvl = ~lvl;
        syms.push_back(lvl);
        ones = 0;
      end
    end
    syms.push_back(2'b00);
    syms.push_back(2'b00);
    syms.push_back(2'b10);
    exp_len_q.push_back(syms.size());
    foreach (syms[i]) exp_sym_q.push_back(syms[i]);
    exp_pops_q.push_back((code == 4'd1) ? pay_q.size() : 0);
    exp_nb_q.push_back(bytes.size());
    foreach (bytes[i]) exp_byte_q.push_back(bytes[i]);
  endtask

  task automatic finish_pkt();
    int len, pops, nb, bad, ones, mism;
    logic [1:0] s, prev;
    bit raw;
    bit bits[$];
    logic [7:0] e, g;
    if (exp_len_q.size() == 0) begin
      chk("unexpected_packet", 1, 0);
      return;
    end
    len  = exp_len_q.pop_front();
    pops = exp_pops_q.pop_front();
    nb   = exp_nb_q.pop_front();
    chk("active_cycles", trace.size(), len * CPB);
    chk("pop_count", pkt_pops, pops);
    bad = -1;
    for (int k = 0; k < len; k++) begin
      s = exp_sym_q.pop_front();
      for (int j = 0; j < CPB; j++) begin
        int idx;
        idx = k * CPB + j;
        if (bad < 0 && (idx >= trace.size() || trace[idx] !== s)) bad = idx;
      end
    end
    chk("first_bad_line_cycle", bad, -1);
    prev = 2'b10;
    ones = 0;
    for (int k = 0; k * CPB + 2 < trace.size(); k++) begin
      s = trace[k * CPB + 2];
      if (s == 2'b00) break;
      raw  = (s == prev);
      prev = s;
      if (ones == 6) begin
        ones = 0;
        continue;
      end
      bits.push_back(raw);
      ones = raw ? ones + 1 : 0;
    end
    chk("decoded_bit_count", bits.size(), nb * 8);
    mism = 0;
    for (int i = 0; i < nb; i++) begin
      e = exp_byte_q.pop_front();
      for (int j = 0; j < 8; j++) g[j] = (i * 8 + j < bits.size()) ? bits[i * 8 + j] : 1'b0;
      if (g !== e) mism++;
    end
    chk("decoded_byte_mismatches", mism, 0);
  endtask

  // Buffer model: data appears the cycle after a pop; 0xEE marks an over-pop.
  always @(negedge clk) begin
    if (pend) begin
      if (buf_q.size() > 0) tx_packet_data = buf_q.pop_front();
      else                  tx_packet_data = 8'hEE;
    end
    pend = get_tx_packet_data;
  end

  always @(negedge clk) begin
    if (tx_error === 1'b1) err_seen++;
    if (tx_transfer_active === 1'b1) begin
      trace.push_back({dplus_out, dminus_out});
      if (get_tx_packet_data) pkt_pops++;
      in_pkt = 1'b1;
    end else begin
      if (get_tx_packet_data === 1'b1) idle_pops++;
      if (in_pkt) begin
        in_pkt = 1'b0;
        if (abort_pkt) abort_pkt = 1'b0;
        else           finish_pkt();
        trace.delete();
        pkt_pops = 0;
      end
    end
  end

  task automatic send(input logic [3:0] code);
    int cyc;
    model_push(code);
    if (code == 4'd1) foreach (pay_q[i]) buf_q.push_back(pay_q[i]);
    @(posedge clk); #1;
    tx_packet        = code;
    buffer_occupancy = (code == 4'd1) ? 7'(pay_q.size()) : 7'($urandom_range(1, 64));
    @(posedge clk); #1;
    // Changes after accept must be ignored.
    tx_packet        = 4'($urandom_range(0, 15));
    buffer_occupancy = 7'($urandom_range(0, 64));
    repeat (8) @(negedge clk);
    tx_packet = 4'd0;
    cyc = 0;
    while (tx_transfer_active !== 1'b0 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    chk("packet_done_in_time", (cyc < 6000) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  task automatic bad_code(input logic [3:0] code);
    int n, v;
    exp_err++;
    @(posedge clk); #1;
    tx_packet = code;
    @(posedge clk); #1;
    tx_packet = 4'd0;
    n = 0;
    v = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_error) n++;
      if (tx_transfer_active || !dplus_out || dminus_out) v++;
    end
    chk("bad_code_err_pulses", n, 1);
    chk("bad_code_idle_violations", v, 0);
  endtask

  initial begin
    int n;
    rst              = 1'b1;
    tx_packet        = 4'd0;
    buffer_occupancy = 7'd0;
    tx_packet_data   = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dplus", dplus_out, 1);
    chk("rst_dminus", dminus_out, 0);
    chk("rst_active", tx_transfer_active, 0);
    chk("rst_get", get_tx_packet_data, 0);
    chk("rst_error", tx_error, 0);
    rst = 1'b0;

    pay_q.delete();
    send(4'd2);                         // ACK
    send(4'd1);                         // zero-length DATA0
    pay_q = '{8'h00, 8'h01};
    send(4'd1);
    pay_q = '{8'hFF};
    send(4'd1);
    bad_code(4'd7);

    // Reset in the middle of a DATA0 payload.
    pay_q.delete();
    for (int i = 0; i < 6; i++) pay_q.push_back(8'($urandom));
    foreach (pay_q[i]) buf_q.push_back(pay_q[i]);
    @(posedge clk); #1;
    tx_packet        = 4'd1;
    buffer_occupancy = 7'd6;
    @(posedge clk); #1;
    tx_packet = 4'd0;
    repeat (150) @(negedge clk);
    chk("mid_data_active", tx_transfer_active, 1);
    abort_pkt = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    chk("midrst_dplus", dplus_out, 1);
    chk("midrst_dminus", dminus_out, 0);
    chk("midrst_active", tx_transfer_active, 0);
    chk("midrst_get", get_tx_packet_data, 0);
    chk("midrst_error", tx_error, 0);
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (get_tx_packet_data) n++;
    end
    chk("pops_after_reset", n, 0);
    buf_q.delete();
    pay_q.delete();
    send(4'd2);

    // Maximum payload, all ones: stuffing throughout.
    for (int i = 0; i < 64; i++) pay_q.push_back(8'hFF);
    send(4'd1);

    for (int p = 0; p < 24; p++) begin
      logic [3:0] code;
      int cnt;
      code = 4'($urandom_range(1, 4));
      pay_q.delete();
      if (code == 4'd1) begin
        cnt = $urandom_range(0, 8);
        for (int i = 0; i < cnt; i++)
          pay_q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      end
      send(code);
      if ($urandom_range(0, 3) == 0) bad_code(4'($urandom_range(5, 15)));
    end

    repeat (4) @(negedge clk);
    chk("idle_pops", idle_pops, 0);
    chk("error_pulses_total", err_seen, exp_err);
    chk("unconsumed_expectations", exp_len_q.size(), 0);
    chk("buffer_left", buf_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
